// File: rtl/common_types_pkg.sv
// Shared pipeline typedefs: stage-boundary payloads and pipeline-buffer depth helpers.
package common_types_pkg;

  typedef logic [2:0] pipe_depth_t;

  localparam pipe_depth_t PIPE_DEPTH_MIN = 3'd1;
  localparam pipe_depth_t PIPE_DEPTH_MAX = 3'd4;

  // Execute -> memory boundary; callers set WIDTH = $bits(ex_mem_payload_t).
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rdat2;
    logic [31:0] alu_out;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        halt;
  } ex_mem_payload_t;

  // Pointer width for a DEPTH-entry array; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_stall_cnt.sv
// Saturating counter of cycles the stage head was offered but not taken.
module pipe_stage_buf_stall_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             stall,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (stall && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH=1 is a classic stage register, DEPTH>=2 a skid
// buffer whose in_ready depends only on registered occupancy.
module pipe_stage_buf
  import common_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt,
  input  logic                       stall_clr
);

  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int PTR_W    = ptr_width(DEPTH);

  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(DEPTH - 1);

  if ((DEPTH < int'(PIPE_DEPTH_MIN)) || (DEPTH > int'(PIPE_DEPTH_MAX))) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be within 1..4");
  end

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    rptr;
  logic [PTR_W-1:0]    wptr;
  logic [CNT_BITS-1:0] count_next;
  logic                full;
  logic                push;
  logic                pop;

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];

  // Only the single-entry stage may refill in the cycle its head leaves.
  if (DEPTH == 1) begin : g_through
    assign in_ready = !full || out_ready;
  end else begin : g_skid
    assign in_ready = !full;
  end

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count <= count_next;
    end
  end

  // NOTE: payload storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= in_data;
  end

  pipe_stage_buf_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .stall (out_valid && !out_ready && !flush),
    .clr   (stall_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Checks DEPTH=1/2/4 instances against a shift-queue model plus directed literal cases.
module tb_pipe_stage_buf;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        stall_clr;

  logic        rdy1, rdy2, rdy4;
  logic        ov1, ov2, ov4;
  logic [31:0] od1, od2, od4;
  logic [0:0]  cnt1;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;
  logic [3:0]  st1;
  logic [31:0] st2;
  logic [3:0]  st4;

  int total = 0;
  int bad   = 0;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .CNT_W(4)) u_d1 (
    .CLK(clk), .nRST(nrst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .flush(flush),
    .count(cnt1), .stall_cnt(st1), .stall_clr(stall_clr));

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(32)) u_d2 (
    .CLK(clk), .nRST(nrst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .flush(flush),
    .count(cnt2), .stall_cnt(st2), .stall_clr(stall_clr));

  pipe_stage_buf #(.WIDTH(32), .DEPTH(4), .CNT_W(4)) u_d4 (
    .CLK(clk), .nRST(nrst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .flush(flush),
    .count(cnt4), .stall_cnt(st4), .stall_clr(stall_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each instance is a plain list, head at index 0.
  int unsigned dep  [3] = '{1, 2, 4};
  logic [31:0] smax [3] = '{32'd15, 32'hFFFF_FFFF, 32'd15};
  logic [31:0] mdata [3][5];
  int          mlen  [3];
  logic [31:0] mst   [3];

  logic        a_rdy [3];
  logic        a_ov  [3];
  logic [31:0] a_od  [3];
  logic [31:0] a_cnt [3];
  logic [31:0] a_st  [3];

  always_comb begin
    a_rdy = '{rdy1, rdy2, rdy4};
    a_ov  = '{ov1, ov2, ov4};
    a_od  = '{od1, od2, od4};
    a_cnt = '{{31'd0, cnt1}, {30'd0, cnt2}, {29'd0, cnt4}};
    a_st  = '{{28'd0, st1}, st2, {28'd0, st4}};
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic er;
      if (!nrst) begin
        mlen[i] = 0;
        mst[i]  = '0;
      end
      er = (mlen[i] < int'(dep[i])) || ((dep[i] == 1) && out_ready);
      check($sformatf("d%0d_in_ready", dep[i]), {31'd0, a_rdy[i]}, {31'd0, er});
      check($sformatf("d%0d_out_valid", dep[i]), {31'd0, a_ov[i]}, {31'd0, mlen[i] > 0});
      check($sformatf("d%0d_count", dep[i]), a_cnt[i], mlen[i]);
      check($sformatf("d%0d_stall_cnt", dep[i]), a_st[i], mst[i]);
      if (mlen[i] > 0) check($sformatf("d%0d_out_data", dep[i]), a_od[i], mdata[i][0]);
      if (nrst) begin
        if (stall_clr) mst[i] = '0;
        else if (mlen[i] > 0 && !out_ready && !flush && mst[i] != smax[i]) mst[i] = mst[i] + 1;
        if (flush) begin
          mlen[i] = 0;
        end else begin
          if (mlen[i] > 0 && out_ready) begin
            for (int k = 0; k < 4; k++) mdata[i][k] = mdata[i][k+1];
            mlen[i]--;
          end
          if (in_valid && er) begin
            mdata[i][mlen[i]] = in_data;
            mlen[i]++;
          end
        end
      end
    end
  end

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                     input logic fl, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (8) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    nrst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, rdy2}, 32'd1);
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    check("idle_out_valid", {31'd0, ov2}, 32'd0);
    check("idle_in_ready", {31'd0, rdy2}, 32'd1);
    check("idle_count", {30'd0, cnt2}, 32'd0);
    check("idle_stall", st2, 32'd0);

    // Streaming, DEPTH=2
    cyc(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    check("stream_d0", od2, 32'h11);
    cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    check("stream_d1", od2, 32'h22);
    check("stream_cnt", {30'd0, cnt2}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("stream_d2", od2, 32'h33);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("stream_empty", {31'd0, ov2}, 32'd0);
    drain();

    // Backpressure, DEPTH=2
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    check("bp_count", {30'd0, cnt2}, 32'd2);
    check("bp_in_ready", {31'd0, rdy2}, 32'd0);
    check("bp_head", od2, 32'hA);
    cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    check("bp_stall_cnt", st2, 32'd4);
    check("bp_out_a", od2, 32'hA);
    check("bp_no_ready_path", {31'd0, rdy2}, 32'd0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    check("bp_out_b", od2, 32'hB);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("bp_out_c", od2, 32'hC);
    drain();

    // DEPTH=1 through-path
    cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("d1_full_in_ready", {31'd0, rdy1}, 32'd0);
    cyc(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    check("d1_through_ready", {31'd0, rdy1}, 32'd1);
    check("d1_head5", od1, 32'h5);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("d1_head6", od1, 32'h6);
    check("d1_count", {31'd0, cnt1}, 32'd1);
    drain();

    // Flush collision, DEPTH=4
    cyc(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h43, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
    check("fl_pre_count", {29'd0, cnt4}, 32'd3);
    check("fl_in_ready", {31'd0, rdy4}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("fl_count", {29'd0, cnt4}, 32'd0);
    check("fl_out_valid", {31'd0, ov4}, 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("fl_nothing_late", {31'd0, ov4}, 32'd0);
    drain();

    // Stall counter saturation, CNT_W=4
    cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sat_stall", {28'd0, st4}, 32'd15);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sat_clr", {28'd0, st4}, 32'd0);
    drain();

    // Asynchronous reset mid-transfer
    cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h56, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("arst_count", {30'd0, cnt2}, 32'd0);
    check("arst_out_valid", {31'd0, ov2}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
    @(negedge clk);
    check("arst_first_ready", {31'd0, rdy2}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("arst_first_push", od2, 32'h99);
    drain();

    // Randomised traffic, alternating downstream pressure per block
    for (int blk = 0; blk < 12; blk++) begin
      int unsigned rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 90 : 55);
      for (int n = 0; n < 200; n++) begin
        cyc($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
